two_bit_program_sequencer: RTL and testbench

- Sequential front end that feeds the combinational two_bit_computer ALU and consumes its results.
- Holds a small program of (opcode, operand) pairs loaded over a valid/ready port.
- On start, executes the program as an accumulator machine: drives acc/operand/opcode into the ALU, captures f1:f0 back into acc, and tracks error.
- Exposes final acc, a sticky error flag, the index of the first faulting instruction, and a done pulse.

---
 rtl/two_bit_pkg.sv | 18 +
 rtl/two_bit_program_sequencer_if.sv | 13 +
 rtl/two_bit_prog_mem.sv | 26 ++
 rtl/two_bit_program_sequencer.sv | 163 ++++++++++++++++
 tb/tb_two_bit_program_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/two_bit_pkg.sv
// Shared types for the two-bit program sequencer: FSM states and program entries.
package two_bit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    typedef logic [1:0] opcode_t;

    typedef struct packed {
        opcode_t    op;
        logic [1:0] operand;
    } prog_entry_t;

endpackage

// File: rtl/two_bit_program_sequencer_if.sv
// Program-load handshake: one (opcode, operand) entry per accepted beat.
interface two_bit_program_sequencer_if;
    import two_bit_pkg::*;

    logic       load_valid;
    logic       load_ready;
    opcode_t    load_op;
    logic [1:0] load_operand;

    modport master (output load_valid, load_op, load_operand, input load_ready);
    modport slave  (input load_valid, load_op, load_operand, output load_ready);

endinterface

// File: rtl/two_bit_prog_mem.sv
// DEPTH x 4 program store: one synchronous write port, one asynchronous read port.
module two_bit_prog_mem
    import two_bit_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [IW-1:0] waddr_i,
    input  prog_entry_t wdata_i,
    input  logic [IW-1:0] raddr_i,
    output prog_entry_t rdata_o
);

    prog_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/two_bit_program_sequencer.sv
// Accumulator-machine front end for the combinational two-bit ALU: loads a program,
// then alternates ISSUE (drive ALU) and CAPTURE (take result) per entry.
module two_bit_program_sequencer
    import two_bit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter bit HALT_ON_ERROR = 1'b1,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    two_bit_program_sequencer_if.slave load_if,
    input  logic          clear_prog,
    input  logic          start,
    input  logic [1:0]    init_acc,
    output logic          busy,
    output logic          done,
    output logic [1:0]    acc,
    output logic          err,
    output logic [IW-1:0] err_index,
    output logic [IW:0]   prog_count,
    output logic          alu_a1,
    output logic          alu_a0,
    output logic          alu_b1,
    output logic          alu_b0,
    output logic          alu_i1,
    output logic          alu_i0,
    input  logic          alu_f1,
    input  logic          alu_f0,
    input  logic          alu_error
);

    localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [IW:0]   count_q, count_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [1:0]    acc_q, acc_d;
    logic          err_q, err_d;
    logic [IW-1:0] err_idx_q, err_idx_d;
    logic [1:0]    alu_a_q, alu_a_d;
    logic [1:0]    alu_b_q, alu_b_d;
    opcode_t       alu_i_q, alu_i_d;

    prog_entry_t   entry;
    logic          load_fire;
    logic          run_req;
    logic          last_entry;
    logic          halt;

    assign load_fire  = load_if.load_valid && load_if.load_ready;
    // clear_prog outranks start, so a simultaneous start is dropped.
    assign run_req    = start && !clear_prog;
    assign last_entry = ({1'b0, pc_q} == (count_q - 1'b1));
    assign halt       = alu_error && HALT_ON_ERROR;

    two_bit_prog_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (load_fire),
        .waddr_i (count_q[IW-1:0]),
        .wdata_i ({load_if.load_op, load_if.load_operand}),
        .raddr_i (pc_q),
        .rdata_o (entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run_req) state_d = (count_q == '0) ? DONE : ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = (halt || last_entry) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_if.load_ready = (state_q == IDLE) && (count_q < DEPTH_C) && !start && !clear_prog;
        busy               = (state_q != IDLE);
        done               = (state_q == DONE);
    end

    always_comb begin
        count_d   = count_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_i_d   = alu_i_q;
        unique case (state_q)
            IDLE: begin
                if (clear_prog) begin
                    count_d = '0;
                end else if (load_fire) begin
                    count_d = count_q + 1'b1;
                end
                if (run_req) begin
                    acc_d     = init_acc;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    pc_d      = '0;
                end
            end
            ISSUE: begin
                alu_a_d = acc_q;
                alu_b_d = entry.operand;
                alu_i_d = entry.op;
            end
            CAPTURE: begin
                acc_d = {alu_f1, alu_f0};
                if (alu_error && !err_q) begin
                    err_d     = 1'b1;
                    err_idx_d = pc_q;
                end
                if (!halt && !last_entry) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            pc_q      <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_i_q   <= '0;
        end else begin
            count_q   <= count_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_i_q   <= alu_i_d;
        end
    end

    assign acc        = acc_q;
    assign err        = err_q;
    assign err_index  = err_idx_q;
    assign prog_count = count_q;
    assign {alu_a1, alu_a0} = alu_a_q;
    assign {alu_b1, alu_b0} = alu_b_q;
    assign {alu_i1, alu_i0} = alu_i_q;

endmodule

// File: tb/tb_two_bit_program_sequencer.sv
// Drives one halting and one non-halting sequencer with identical stimulus; a stub ALU
// closes each loop and a per-instance scoreboard checks every done pulse.
module tb_two_bit_program_sequencer;
    import two_bit_pkg::*;

    typedef struct {
        int acc;
        int err;
        int idx;
        int lat;
        int e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       start;
    logic [1:0] init_acc;
    logic       lv;
    logic [1:0] lop;
    logic [1:0] lopd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q_h[$];
    exp_t q_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] alu_stub(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                return {s[1:0], s[2]};
            end
            2'b01:   return {a - b, (a < b)};
            2'b10:   return {a ^ b, 1'b0};
            default: return {b, 1'b0};
        endcase
    endfunction

    two_bit_program_sequencer_if ifh ();
    two_bit_program_sequencer_if ifc ();
    assign ifh.load_valid   = lv;
    assign ifh.load_op      = lop;
    assign ifh.load_operand = lopd;
    assign ifc.load_valid   = lv;
    assign ifc.load_op      = lop;
    assign ifc.load_operand = lopd;

    logic       busy_h, done_h, err_h, busy_c, done_c, err_c;
    logic [1:0] acc_h, acc_c;
    logic [2:0] eidx_h, eidx_c;
    logic [3:0] cnt_h, cnt_c;
    logic [5:0] alu_h, alu_c;
    logic [2:0] res_h, res_c;

    assign res_h = alu_stub(alu_h[1:0], alu_h[5:4], alu_h[3:2]);
    assign res_c = alu_stub(alu_c[1:0], alu_c[5:4], alu_c[3:2]);

    two_bit_program_sequencer #(.DEPTH(8), .HALT_ON_ERROR(1'b1)) dut_h (
        .clk(clk), .rst(rst), .load_if(ifh), .clear_prog(clr), .start(start),
        .init_acc(init_acc), .busy(busy_h), .done(done_h), .acc(acc_h), .err(err_h),
        .err_index(eidx_h), .prog_count(cnt_h),
        .alu_a1(alu_h[5]), .alu_a0(alu_h[4]), .alu_b1(alu_h[3]), .alu_b0(alu_h[2]),
        .alu_i1(alu_h[1]), .alu_i0(alu_h[0]),
        .alu_f1(res_h[2]), .alu_f0(res_h[1]), .alu_error(res_h[0])
    );

    two_bit_program_sequencer #(.DEPTH(8), .HALT_ON_ERROR(1'b0)) dut_c (
        .clk(clk), .rst(rst), .load_if(ifc), .clear_prog(clr), .start(start),
        .init_acc(init_acc), .busy(busy_c), .done(done_c), .acc(acc_c), .err(err_c),
        .err_index(eidx_c), .prog_count(cnt_c),
        .alu_a1(alu_c[5]), .alu_a0(alu_c[4]), .alu_b1(alu_c[3]), .alu_b0(alu_c[2]),
        .alu_i1(alu_c[1]), .alu_i0(alu_c[0]),
        .alu_f1(res_c[2]), .alu_f0(res_c[1]), .alu_error(res_c[0])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done_h) begin
            if (q_h.size() == 0) begin
                check("halt: unexpected done", 1, 0);
            end else begin
                exp_t x;
                x = q_h.pop_front();
                check("halt: acc", int'(acc_h), x.acc);
                check("halt: err", int'(err_h), x.err);
                check("halt: err_index", int'(eidx_h), x.idx);
                check("halt: latency", cyc - x.e, x.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done_c) begin
            if (q_c.size() == 0) begin
                check("cont: unexpected done", 1, 0);
            end else begin
                exp_t x;
                x = q_c.pop_front();
                check("cont: acc", int'(acc_c), x.acc);
                check("cont: err", int'(err_c), x.err);
                check("cont: err_index", int'(eidx_c), x.idx);
                check("cont: latency", cyc - x.e, x.lat);
            end
        end
    end

    task automatic load_entry(input logic [1:0] op, input logic [1:0] opd);
        int n;
        @(negedge clk);
        lv = 1'b1;
        lop = op;
        lopd = opd;
        #1;
        n = 0;
        while (!ifh.load_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 20) check("load: ready timeout", 0, 1);
        @(negedge clk);
        lv = 1'b0;
    endtask

    task automatic clear_program();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clear: count halt", int'(cnt_h), 0);
        check("clear: count cont", int'(cnt_c), 0);
    endtask

    task automatic run(input logic [1:0] ia, input exp_t eh, input exp_t ec, input bit pulse);
        int n;
        @(negedge clk);
        start = 1'b1;
        init_acc = ia;
        @(posedge clk);
        #1;
        start = 1'b0;
        eh.e = cyc;
        ec.e = cyc;
        q_h.push_back(eh);
        q_c.push_back(ec);
        if (pulse) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while ((q_h.size() != 0 || q_c.size() != 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q_h.size() != 0 || q_c.size() != 0) begin
            check("run: done timeout", 0, 1);
            q_h.delete();
            q_c.delete();
        end
    endtask

    initial begin
        exp_t eh, ec;
        rst = 1'b1;
        clr = 1'b0;
        start = 1'b0;
        init_acc = 2'd0;
        lv = 1'b0;
        lop = 2'd0;
        lopd = 2'd0;
        repeat (3) @(negedge clk);
        check("reset: busy", int'(busy_h), 0);
        check("reset: done", int'(done_h), 0);
        check("reset: acc", int'(acc_h), 0);
        check("reset: err", int'(err_h), 0);
        check("reset: err_index", int'(eidx_h), 0);
        check("reset: prog_count", int'(cnt_h), 0);
        check("reset: alu drive", int'(alu_h), 0);
        check("reset: load_ready", int'(ifh.load_ready), 1);
        rst = 1'b0;

        // Clean program 0+1+1-1, with a start pulse landing mid-run.
        load_entry(2'b00, 2'd1);
        load_entry(2'b00, 2'd1);
        load_entry(2'b01, 2'd1);
        check("load: count", int'(cnt_h), 3);
        eh = '{acc: 1, err: 0, idx: 0, lat: 6, e: 0};
        run(2'd0, eh, eh, 1'b1);

        // 0+1+1 then 2-3 borrows on the final entry.
        clear_program();
        load_entry(2'b00, 2'd1);
        load_entry(2'b00, 2'd1);
        load_entry(2'b01, 2'd3);
        eh = '{acc: 3, err: 1, idx: 2, lat: 6, e: 0};
        run(2'd0, eh, eh, 1'b0);

        // 2+3 overflows at entry 0: halting instance stops, the other continues 1+1+1.
        clear_program();
        load_entry(2'b00, 2'd3);
        load_entry(2'b00, 2'd1);
        load_entry(2'b00, 2'd1);
        eh = '{acc: 1, err: 1, idx: 0, lat: 2, e: 0};
        ec = '{acc: 3, err: 1, idx: 0, lat: 6, e: 0};
        run(2'd2, eh, ec, 1'b0);
        repeat (3) @(negedge clk);
        check("hold: acc halt", int'(acc_h), 1);
        check("hold: err halt", int'(err_h), 1);
        check("hold: acc cont", int'(acc_c), 3);
        check("hold: busy cont", int'(busy_c), 0);

        // Fill to DEPTH, refuse a ninth entry, then run an empty program.
        clear_program();
        for (int i = 0; i < 8; i++) load_entry(2'b00, 2'd0);
        check("full: count", int'(cnt_h), 8);
        check("full: load_ready", int'(ifh.load_ready), 0);
        @(negedge clk);
        lv = 1'b1;
        repeat (2) @(negedge clk);
        check("full: ninth ready", int'(ifh.load_ready), 0);
        check("full: ninth count", int'(cnt_h), 8);
        lv = 1'b0;
        clear_program();
        eh = '{acc: 3, err: 0, idx: 0, lat: 0, e: 0};
        run(2'd3, eh, eh, 1'b0);

        // Reset while capturing entry 1 aborts the run without a done pulse.
        load_entry(2'b00, 2'd1);
        load_entry(2'b00, 2'd1);
        load_entry(2'b00, 2'd1);
        @(negedge clk);
        start = 1'b1;
        init_acc = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort: busy before rst", int'(busy_h), 1);
        check("abort: alu drive entry1", int'(alu_h), 6'h14);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort: busy", int'(busy_h), 0);
        check("abort: done", int'(done_h), 0);
        check("abort: acc", int'(acc_h), 0);
        check("abort: err", int'(err_h), 0);
        check("abort: alu drive", int'(alu_h), 0);
        check("abort: count", int'(cnt_h), 0);
        check("abort: busy cont", int'(busy_c), 0);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
